// File: rtl/jtag_user_tap.sv
// jtag_user_tap: clk-oversampled IEEE 1149.1 TAP with IDCODE, BYPASS and four external user chains
module jtag_user_tap #(
  parameter int                  IR_WIDTH   = 6,
  parameter logic [31:0]         IDCODE_VAL = 32'h0000_0093,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = 6'h09,
  parameter logic [IR_WIDTH-1:0] OP_USER1   = 6'h02,
  parameter logic [IR_WIDTH-1:0] OP_USER2   = 6'h03,
  parameter logic [IR_WIDTH-1:0] OP_USER3   = 6'h22,
  parameter logic [IR_WIDTH-1:0] OP_USER4   = 6'h23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       tdo_oe,
  input  logic [3:0] user_tdo,
  output logic       jtag_reset,
  output logic       jtag_capture,
  output logic       jtag_shift,
  output logic       jtag_update,
  output logic       jtag_runtest,
  output logic [3:0] jtag_sel,
  output logic       tck_rise,
  output logic       tck_fall
);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } state_t;
  state_t state_q, state_d, nxt;
  logic [2:0] tck_q;
  logic [1:0] tms_q, tdi_q, arm_q;
  logic tck_rise_q, tck_fall_q, tms_s, tdi_s, tdo_q, tdo_src;
  logic [5:0] out_q, out_d;
  logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
  logic [31:0] dr_sr_q;
  logic byp_q;
  assign tms_s = tms_q[1];
  assign tdi_s = tdi_q[1];
  assign tck_rise = tck_rise_q;
  assign tck_fall = tck_fall_q;
  assign tdo = tdo_q;
  assign {jtag_reset, jtag_runtest, jtag_capture, jtag_shift, jtag_update, tdo_oe} = out_q;
  // Synchronize pins; edges are only reported once the third tck flop holds a real sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tck_q      <= '0;
      tms_q      <= '0;
      tdi_q      <= '0;
      arm_q      <= '0;
      tck_rise_q <= 1'b0;
      tck_fall_q <= 1'b0;
    end else begin
      tck_q      <= {tck_q[1:0], tck};
      tms_q      <= {tms_q[0], tms};
      tdi_q      <= {tdi_q[0], tdi};
      arm_q      <= (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
      tck_rise_q <= (arm_q == 2'd3) & tck_q[1] & ~tck_q[2];
      tck_fall_q <= (arm_q == 2'd3) & ~tck_q[1] & tck_q[2];
    end
  // TAP state and its registered decodes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= TLR;
      out_q   <= 6'b100000;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  // Standard 1149.1 transitions, taken only on a detected tck rise
  always_comb begin
    unique case (state_q)
      TLR:    nxt = tms_s ? TLR    : RTI;
      RTI:    nxt = tms_s ? SEL_DR : RTI;
      SEL_DR: nxt = tms_s ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms_s ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms_s ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms_s ? UPD_DR : PAU_DR;
      PAU_DR: nxt = tms_s ? EX2_DR : PAU_DR;
      EX2_DR: nxt = tms_s ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms_s ? SEL_DR : RTI;
      SEL_IR: nxt = tms_s ? TLR    : CAP_IR;
      CAP_IR: nxt = tms_s ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms_s ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms_s ? UPD_IR : PAU_IR;
      PAU_IR: nxt = tms_s ? EX2_IR : PAU_IR;
      EX2_IR: nxt = tms_s ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms_s ? SEL_DR : RTI;
    endcase
    state_d = tck_rise_q ? nxt : state_q;
  end
  // Decode the upcoming state so the flags change together with state_q
  always_comb begin
    out_d = {state_d == TLR, state_d == RTI, state_d == CAP_DR, state_d == SH_DR,
             state_d == UPD_DR, state_d == SH_DR || state_d == SH_IR};
  end
  // Instruction and data registers: capture/shift on the rise leaving the state, update on the rise entering Update-IR
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ir_q    <= OP_IDCODE;
      ir_sr_q <= '0;
      dr_sr_q <= '0;
      byp_q   <= 1'b0;
    end else begin
      if (state_q == TLR) ir_q <= OP_IDCODE;
      else if (tck_rise_q && state_d == UPD_IR) ir_q <= ir_sr_q;
      if (tck_rise_q && state_q == CAP_IR) ir_sr_q <= IR_WIDTH'(1);
      else if (tck_rise_q && state_q == SH_IR) ir_sr_q <= {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
      if (tck_rise_q && state_q == CAP_DR) begin
        dr_sr_q <= IDCODE_VAL;
        byp_q   <= 1'b0;
      end else if (tck_rise_q && state_q == SH_DR) begin
        dr_sr_q <= {tdi_s, dr_sr_q[31:1]};
        byp_q   <= tdi_s;
      end
    end
  // User chain select and serial-out source selection
  always_comb begin
    jtag_sel = {ir_q == OP_USER4, ir_q == OP_USER3, ir_q == OP_USER2, ir_q == OP_USER1};
    tdo_src  = (state_q == SH_IR) ? ir_sr_q[0] :
               (ir_q == OP_IDCODE) ? dr_sr_q[0] :
               (|jtag_sel) ? |(jtag_sel & user_tdo) : byp_q;
  end
  // tdo moves only on tck fall while shifting and is forced low elsewhere
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tdo_q <= 1'b0;
    else if (!tdo_oe) tdo_q <= 1'b0;
    else if (tck_fall_q) tdo_q <= tdo_src;
endmodule

// File: tb/tb_jtag_user_tap.sv
// tb_jtag_user_tap: scoreboard bench driving a slow tck against the oversampled TAP
module tb_jtag_user_tap;
  logic clk = 1'b0, rst_n = 1'b1, tck = 1'b1, tms = 1'b1, tdi = 1'b0;
  logic [3:0] user_tdo = 4'b0;
  logic tdo, tdo_oe, jtag_reset, jtag_capture, jtag_shift, jtag_update, jtag_runtest;
  logic tck_rise, tck_fall;
  logic [3:0] jtag_sel;
  int errors = 0, checks = 0, upd_cnt = 0;
  logic exp_q[$];
  logic obs_q[$];
  logic cap_v, sh_v;
  localparam logic [31:0] IDC = 32'h0000_0093;

  jtag_user_tap dut (
    .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
    .user_tdo(user_tdo), .jtag_reset(jtag_reset), .jtag_capture(jtag_capture),
    .jtag_shift(jtag_shift), .jtag_update(jtag_update), .jtag_runtest(jtag_runtest),
    .jtag_sel(jtag_sel), .tck_rise(tck_rise), .tck_fall(tck_fall)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (jtag_update) upd_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task tck_pulse(input logic m, input logic d);
    @(negedge clk);
    tms = m;
    tdi = d;
    repeat (4) @(negedge clk);
    tck = 1'b1;
    repeat (5) @(negedge clk);
    tck = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task scan(input logic ir, input logic [31:0] din, input int n, input logic [3:0] um, input logic [31:0] ud);
    obs_q.delete();
    sh_v = 1'b1;
    tck_pulse(1'b1, 1'b0);
    if (ir) tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    cap_v = jtag_capture;
    for (int j = 0; j <= n; j++) begin
      if (j < n) user_tdo = ud[j] ? um : ~um;
      tck_pulse(j == n, (j == 0) ? 1'b0 : din[j-1]);
      if (j < n) begin
        obs_q.push_back(tdo);
        sh_v = sh_v & tdo_oe & (jtag_shift ^ ir);
      end
    end
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
  endtask

  task test_reset;
    int n;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({jtag_reset, jtag_runtest, jtag_capture, jtag_shift, jtag_update} !== 5'b10000) begin errors++; $display("FAIL reset_state: got %b expected 10000", {jtag_reset, jtag_runtest, jtag_capture, jtag_shift, jtag_update}); end
    checks++; if (jtag_sel !== 4'b0) begin errors++; $display("FAIL reset_sel: got %b expected 0000", jtag_sel); end
    checks++; if ({tdo, tdo_oe} !== 2'b00) begin errors++; $display("FAIL reset_tdo: got %b expected 00", {tdo, tdo_oe}); end
    checks++; if ({tck_rise, tck_fall} !== 2'b00) begin errors++; $display("FAIL reset_edges: got %b expected 00", {tck_rise, tck_fall}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (tck_rise) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL no_spurious_rise: got %0d pulses expected 0", n); end
    tck = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (jtag_reset !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b expected 1", jtag_reset); end
  endtask

  task test_runtest;
    tck_pulse(1'b0, 1'b0);
    checks++; if ({jtag_reset, jtag_runtest} !== 2'b01) begin errors++; $display("FAIL runtest: got %b expected 01", {jtag_reset, jtag_runtest}); end
  endtask

  task test_edge_latency;
    @(negedge clk);
    tck = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (tck_rise !== (k == 3)) begin errors++; $display("FAIL rise_latency_%0d: got %b expected %b", k, tck_rise, k == 3); end
    end
    tck = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (tck_fall !== (k == 3)) begin errors++; $display("FAIL fall_latency_%0d: got %b expected %b", k, tck_fall, k == 3); end
    end
    repeat (4) @(negedge clk);
  endtask

  task test_idcode;
    logic [31:0] v;
    logic e, o;
    v = IDC;
    for (int i = 0; i < 32; i++) exp_q.push_back(v[i]);
    scan(1'b0, 32'h0, 32, 4'h0, 32'h0);
    checks++; if (cap_v !== 1'b1) begin errors++; $display("FAIL idcode_capture: got %b expected 1", cap_v); end
    checks++; if (sh_v !== 1'b1) begin errors++; $display("FAIL idcode_shift_flags: got %b expected 1", sh_v); end
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL idcode_bit%0d: got %b expected %b", i, o, e); end
    end
  endtask

  task test_user1;
    logic [31:0] ud;
    logic e, o;
    int u;
    for (int i = 0; i < 6; i++) exp_q.push_back(i == 0);
    scan(1'b1, 32'h02, 6, 4'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL ir_capture_bit%0d: got %b expected %b", i, o, e); end
    end
    checks++; if (jtag_sel !== 4'b0001) begin errors++; $display("FAIL user1_sel: got %b expected 0001", jtag_sel); end
    ud = 32'h0000_00B4;
    for (int i = 0; i < 8; i++) exp_q.push_back(ud[i]);
    u = upd_cnt;
    scan(1'b0, 32'h0, 8, 4'b0001, ud);
    checks++; if (sh_v !== 1'b1) begin errors++; $display("FAIL user1_shift_flags: got %b expected 1", sh_v); end
    checks++; if (upd_cnt <= u) begin errors++; $display("FAIL user1_update: got %0d update cycles expected >0", upd_cnt - u); end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL user1_bit%0d: got %b expected %b", i, o, e); end
    end
  endtask

  task test_sel_table;
    logic [5:0] ops [6] = '{6'h02, 6'h03, 6'h22, 6'h23, 6'h09, 6'h15};
    logic [3:0] sels [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    for (int k = 0; k < 6; k++) begin
      scan(1'b1, {26'h0, ops[k]}, 6, 4'h0, 32'h0);
      checks++; if (jtag_sel !== sels[k]) begin errors++; $display("FAIL sel_op%0h: got %b expected %b", ops[k], jtag_sel, sels[k]); end
    end
  endtask

  task test_bypass;
    logic e, o;
    scan(1'b1, 32'h3F, 6, 4'h0, 32'h0);
    checks++; if (jtag_sel !== 4'b0) begin errors++; $display("FAIL bypass_sel: got %b expected 0000", jtag_sel); end
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    scan(1'b0, 32'b1101, 4, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bypass_bit%0d: got %b expected %b", i, o, e); end
    end
  endtask

  task test_tms_reset;
    logic [31:0] v;
    logic e, o;
    scan(1'b1, 32'h02, 6, 4'h0, 32'h0);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0);
    checks++; if ({tdo_oe, jtag_shift} !== 2'b10) begin errors++; $display("FAIL shift_ir_flags: got %b expected 10", {tdo_oe, jtag_shift}); end
    repeat (5) tck_pulse(1'b1, 1'b1);
    checks++; if (jtag_reset !== 1'b1) begin errors++; $display("FAIL tms_reset_state: got %b expected 1", jtag_reset); end
    checks++; if (jtag_sel !== 4'b0) begin errors++; $display("FAIL tms_reset_sel: got %b expected 0000", jtag_sel); end
    tck_pulse(1'b0, 1'b0);
    v = IDC;
    for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
    scan(1'b0, 32'h0, 8, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL tms_reset_idcode_bit%0d: got %b expected %b", i, o, e); end
    end
  endtask

  task test_back_to_back;
    logic [31:0] v;
    logic e, o;
    int u;
    scan(1'b1, 32'h03, 6, 4'h0, 32'h0);
    checks++; if (jtag_sel !== 4'b0010) begin errors++; $display("FAIL user2_sel: got %b expected 0010", jtag_sel); end
    user_tdo = 4'b0010;
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b1);
    checks++; if ({jtag_shift, tdo} !== 2'b11) begin errors++; $display("FAIL user2_mid_shift: got %b expected 11", {jtag_shift, tdo}); end
    u = upd_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({jtag_reset, jtag_runtest, jtag_capture, jtag_shift, jtag_update} !== 5'b10000) begin errors++; $display("FAIL abort_state: got %b expected 10000", {jtag_reset, jtag_runtest, jtag_capture, jtag_shift, jtag_update}); end
    checks++; if ({jtag_sel, tdo, tdo_oe} !== 6'b0) begin errors++; $display("FAIL abort_outputs: got %b expected 000000", {jtag_sel, tdo, tdo_oe}); end
    tck_pulse(1'b1, 1'b1);
    tck_pulse(1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b1, 1'b0);
    checks++; if (upd_cnt !== u) begin errors++; $display("FAIL abort_no_update: got %0d update cycles expected 0", upd_cnt - u); end
    checks++; if (jtag_reset !== 1'b1) begin errors++; $display("FAIL abort_tlr: got %b expected 1", jtag_reset); end
    tck_pulse(1'b0, 1'b0);
    v = IDC;
    for (int i = 0; i < 32; i++) exp_q.push_back(v[i]);
    scan(1'b0, 32'hFFFF_FFFF, 32, 4'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL recover_idcode_bit%0d: got %b expected %b", i, o, e); end
    end
  endtask

  initial begin
    test_reset;
    test_runtest;
    test_edge_latency;
    test_idcode;
    test_user1;
    test_sel_table;
    test_bypass;
    test_tms_reset;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
